// File: rtl/pushbutton_event_ctrl.sv
// Avalon-MM master for the 4-button PIO: initialises mask/captures, services
// each irq with a read + write-1-clear, and queues time-stamped button events.
module pushbutton_event_ctrl #(
  parameter logic [3:0] MASK       = 4'hF,
  parameter int         FIFO_DEPTH = 4,
  parameter int         STAMP_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               irq,
  input  logic [31:0]        avm_readdata,
  output logic [1:0]         avm_address,
  output logic               avm_chipselect,
  output logic               avm_write_n,
  output logic [31:0]        avm_writedata,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [STAMP_W+3:0] evt_data,
  output logic [7:0]         overflow_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_INIT_MASK, S_INIT_CLR, S_IDLE, S_RD, S_WAIT, S_CLR
  } state_t;

  state_t               r_state, w_next;
  logic                 r_go;
  logic [3:0]           r_cap;
  logic [STAMP_W-1:0]   r_stamp, r_stamp_lat;
  logic [1:0]           r_addr, w_addr;
  logic                 r_cs, w_cs, r_wn, w_wn;
  logic [31:0]          r_wdata, w_wdata;
  logic [3:0]           w_cap;
  logic [AW:0]          r_wp, r_rp;
  logic [STAMP_W+3:0]   r_mem [FIFO_DEPTH];
  logic [7:0]           r_ovf;
  logic                 w_empty, w_full, w_pop, w_push_req, w_push;
  logic                 w_unused;

  assign w_cap    = avm_readdata[3:0] & MASK;
  assign w_unused = ^avm_readdata[31:4];

  // r_go holds INIT_MASK for the reset-release cycle so the mask write
  // lands in the first cycle after release.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT_MASK: if (r_go) w_next = S_INIT_CLR;
      S_INIT_CLR:  w_next = S_IDLE;
      S_IDLE:      if (irq) w_next = S_RD;
      S_RD:        w_next = S_WAIT;
      S_WAIT:      w_next = (w_cap != 4'h0) ? S_CLR : S_IDLE;
      S_CLR:       w_next = S_IDLE;
      default:     w_next = S_INIT_MASK;
    endcase
  end

  // Bus drive is decoded from the next state and registered, so it is
  // stable for the whole cycle the FSM sits in the access state.
  always_comb begin
    w_cs    = 1'b0;
    w_wn    = 1'b1;
    w_addr  = 2'd0;
    w_wdata = 32'h0;
    unique case (w_next)
      S_INIT_MASK: begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 2'd2; w_wdata = {28'h0, MASK}; end
      S_INIT_CLR:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 2'd3; w_wdata = 32'hF; end
      S_RD:        begin w_cs = 1'b1; w_addr = 2'd3; end
      S_CLR:       begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 2'd3; w_wdata = {28'h0, w_cap}; end
      default:     ;
    endcase
  end

  assign w_empty    = (r_wp == r_rp);
  assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop      = !w_empty && evt_ready;
  assign w_push_req = (r_state == S_CLR);
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_INIT_MASK;
      r_go        <= 1'b0;
      r_cs        <= 1'b0;
      r_wn        <= 1'b1;
      r_addr      <= 2'd0;
      r_wdata     <= 32'h0;
      r_stamp     <= '0;
      r_stamp_lat <= '0;
      r_cap       <= 4'h0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_ovf       <= 8'h0;
    end else begin
      r_state <= w_next;
      r_go    <= 1'b1;
      r_cs    <= w_cs;
      r_wn    <= w_wn;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_stamp <= r_stamp + STAMP_W'(1);
      if (r_state == S_WAIT) begin
        r_cap       <= w_cap;
        r_stamp_lat <= r_stamp;
      end
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
      if (w_push_req && !w_push && r_ovf != 8'hFF) r_ovf <= r_ovf + 8'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_push) r_mem[r_wp[AW-1:0]] <= {r_stamp_lat, r_cap};
  end

  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wn;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign evt_valid      = !w_empty;
  assign evt_data       = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign overflow_count = r_ovf;
endmodule

// File: tb/tb_pushbutton_event_ctrl.sv
// Directed bench: behavioural PIO drives the main instance; a MASK=1 instance
// sees a forced irq with readdata 0x2 to exercise the spurious-irq path.
module tb_pushbutton_event_ctrl;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        evt_ready = 1'b0;
  logic [3:0]  btn_edge = 4'h0;

  logic        irq;
  logic [31:0] pio_rd = 32'h0;
  logic [1:0]  addr;
  logic        cs, wn, evt_valid;
  logic [31:0] wdata;
  logic [19:0] evt_data;
  logic [7:0]  ovf;

  logic        m_irq = 1'b1;
  logic [31:0] m_rd = 32'h2;
  logic [1:0]  m_addr;
  logic        m_cs, m_wn, m_valid;
  logic [31:0] m_wdata;
  logic [19:0] m_data;
  logic [7:0]  m_ovf;

  logic [3:0]  pio_cap = 4'h0, pio_mask = 4'h0;
  int          cyc = 0, n_chk = 0, n_err = 0, clr_cnt = 0, clr0 = 0;
  bit          m_watch = 1'b0, m_bad = 1'b0;
  logic [15:0] exp_st [4];

  pushbutton_event_ctrl #(.MASK(4'hF), .FIFO_DEPTH(4), .STAMP_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .avm_readdata(pio_rd),
    .avm_address(addr), .avm_chipselect(cs), .avm_write_n(wn), .avm_writedata(wdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .overflow_count(ovf));

  pushbutton_event_ctrl #(.MASK(4'h1), .FIFO_DEPTH(4), .STAMP_W(16)) u_m (
    .clk(clk), .reset_n(reset_n), .irq(m_irq), .avm_readdata(m_rd),
    .avm_address(m_addr), .avm_chipselect(m_cs), .avm_write_n(m_wn), .avm_writedata(m_wdata),
    .evt_valid(m_valid), .evt_ready(1'b0), .evt_data(m_data),
    .overflow_count(m_ovf));

  // PIO: edge capture with write-1-clear priority, registered readdata.
  assign irq = |(pio_cap & pio_mask);
  always @(posedge clk) begin
    if (cs && !wn && addr == 2'd2) pio_mask <= wdata[3:0];
    if (cs && !wn && addr == 2'd3) pio_cap <= (pio_cap | btn_edge) & ~wdata[3:0];
    else                           pio_cap <= pio_cap | btn_edge;
    pio_rd <= (cs && wn) ? ((addr == 2'd3) ? {28'h0, pio_cap} :
                            (addr == 2'd2) ? {28'h0, pio_mask} : 32'h0) : 32'h0;
    if (reset_n && cs && !wn && addr == 2'd3) clr_cnt <= clr_cnt + 1;
    if (m_watch && ((m_cs && !m_wn) || m_valid)) m_bad <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0h: got %h want %h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    cyc = 0;
    reset_n = 1'b1;
  endtask

  task automatic press(input int at, input logic [3:0] b);
    run_to(at);
    btn_edge = b;
    tick();
    btn_edge = 4'h0;
  endtask

  initial begin
    // reset and init sequence
    do_reset();
    chk("rst_cs", 32'(cs), 32'h0);
    chk("rst_wn", 32'(wn), 32'h1);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_data", 32'(evt_data), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    tick();
    chk("init1_bus", {29'h0, cs, wn, 1'b0} | 32'(addr) << 4, 32'h24);
    chk("init1_data", wdata, 32'hF);
    chk("m_init1_data", m_wdata, 32'h1);
    tick();
    chk("init2_bus", {29'h0, cs, wn, 1'b0} | 32'(addr) << 4, 32'h34);
    chk("init2_data", wdata, 32'hF);
    tick();
    chk("idle_cs", 32'(cs), 32'h0);
    chk("idle_wn", 32'(wn), 32'h1);
    m_watch = 1'b1;
    // masked instance: RD, WAIT, IDLE, RD with no clear write
    tick(); chk("m_rd4", {30'h0, m_cs, m_wn}, 32'h3);
    tick(); chk("m_wait5", 32'(m_cs), 32'h0);
    tick(); chk("m_idle6", 32'(m_cs), 32'h0);
    tick(); chk("m_rd7", {30'h0, m_cs, m_wn}, 32'h3);

    // button 2, WAIT at stamp 0x10
    press(8'h0D, 4'h4);
    run_to(8'h0F);
    chk("b2_rd", {30'h0, cs, wn} | 32'(addr) << 4, 32'h33);
    tick(); chk("b2_wait_cs", 32'(cs), 32'h0);
    tick();
    chk("b2_clr", {30'h0, cs, wn} | 32'(addr) << 4, 32'h32);
    chk("b2_clr_data", wdata, 32'h4);
    tick();
    chk("b2_valid", 32'(evt_valid), 32'h1);
    chk("b2_data", 32'(evt_data), 32'h00104);
    chk("b2_irq", 32'(irq), 32'h0);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("b2_popped", 32'(evt_valid), 32'h0);

    // button 1 service with button 0 arriving during RD
    press(8'h20, 4'h2);
    press(8'h22, 4'h1);
    run_to(8'h24);
    chk("mrg_clr1", wdata, 32'h2);
    tick();
    chk("mrg_ev1", 32'(evt_data), 32'h00232);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    run_to(8'h28);
    chk("mrg_clr2", wdata, 32'h1);
    tick();
    chk("mrg_ev2_v", 32'(evt_valid), 32'h1);
    chk("mrg_ev2", 32'(evt_data), 32'h00271);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // five events into a four-deep FIFO
    clr0 = clr_cnt;
    for (int i = 0; i < 5; i++) begin
      press(8'h40 + 6 * i, 4'(1 << (i % 4)));
      if (i < 4) exp_st[i] = 16'(8'h43 + 6 * i);
    end
    run_to(8'h60);
    chk("full_ovf", 32'(ovf), 32'h1);
    chk("full_irq", 32'(irq), 32'h0);
    chk("full_clrs", 32'(clr_cnt - clr0), 32'h5);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_v", 32'(evt_valid), 32'h1);
      chk("drain_d", 32'(evt_data), 32'({exp_st[i], 4'(1 << i)}));
      tick();
    end
    chk("drain_empty", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;

    // reset during CLR
    press(8'h70, 4'h8);
    run_to(8'h74);
    chk("rc_clr_data", wdata, 32'h8);
    m_watch = 1'b0;
    chk("m_no_write_evt", 32'(m_bad), 32'h0);
    do_reset();
    chk("rc_valid", 32'(evt_valid), 32'h0);
    chk("rc_ovf", 32'(ovf), 32'h0);
    chk("rc_cs", 32'(cs), 32'h0);
    tick();
    chk("rc_init", {30'h0, cs, wn} | 32'(addr) << 4, 32'h22);
    chk("rc_empty", 32'(evt_valid), 32'h0);

    // stamp wrap
    press(32'hFFFC, 4'h8);
    run_to(32'h10000);
    chk("wrap_pre_v", 32'(evt_valid), 32'h0);
    tick();
    chk("wrap_ev1", 32'(evt_data), 32'hFFFF8);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    press(32'h10002, 4'h1);
    run_to(32'h10007);
    chk("wrap_ev2_v", 32'(evt_valid), 32'h1);
    chk("wrap_ev2", 32'(evt_data), 32'h00051);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
